control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 32 +++
 rtl/control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, ALU selects, FSM states
// and the decode record handed from ctrl_decode to the sequencer.
package cpu_pkg;

    localparam int PC_W        = 4;
    localparam int MEM_TIMEOUT = 15;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_SUBI = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOR  = 4'h7,
        OP_NAND = 4'h8,
        OP_HALT = 4'h9,
        OP_LSL  = 4'hA,
        OP_BL   = 4'hB,
        OP_BEQ  = 4'hC,
        OP_BR   = 4'hD,
        OP_STUR = 4'hE,
        OP_LDUR = 4'hF
    } opcode_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_NAND = 3'b110;
    localparam logic [2:0] ALU_LSL  = 3'b111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_HALT   = 2'd3
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [2:0] alu_sel;
        logic       alu_b_imm;
    } dec_t;

    function automatic logic [15:0] zext4(input logic [3:0] v);
        return {12'h000, v};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decode: instruction class, ALU select and
// whether the B operand is the immediate rm field.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec.cls       = CLS_ALU;
        dec.alu_sel   = ALU_ADD;
        dec.alu_b_imm = 1'b0;
        case (opcode)
            OP_ADD:  dec.alu_sel = ALU_ADD;
            OP_ADDI: begin dec.alu_sel = ALU_ADD; dec.alu_b_imm = 1'b1; end
            OP_SUB:  dec.alu_sel = ALU_SUB;
            OP_SUBI: begin dec.alu_sel = ALU_SUB; dec.alu_b_imm = 1'b1; end
            OP_AND:  dec.alu_sel = ALU_AND;
            OP_OR:   dec.alu_sel = ALU_OR;
            OP_XOR:  dec.alu_sel = ALU_XOR;
            OP_NOR:  dec.alu_sel = ALU_NOR;
            OP_NAND: dec.alu_sel = ALU_NAND;
            OP_LSL:  begin dec.alu_sel = ALU_LSL; dec.alu_b_imm = 1'b1; end
            OP_HALT: dec.cls = CLS_HALT;
            OP_BL, OP_BEQ, OP_BR: dec.cls = CLS_BRANCH;
            OP_STUR, OP_LDUR:     dec.cls = CLS_MEM;
            default: dec.cls = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM,
// program counter and data-RAM timeout watchdog.
module control_unit #(
    parameter int PC_W        = cpu_pkg::PC_W,
    parameter int MEM_TIMEOUT = cpu_pkg::MEM_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     instr,
    input  logic            imem_valid,
    input  logic            mem_ack,
    input  logic [15:0]     rn_data,
    input  logic [15:0]     rd_data,
    output logic [PC_W-1:0] pc,
    output logic            instr_req,
    output logic [3:0]      rd_f,
    output logic [3:0]      rn_f,
    output logic [3:0]      rm_f,
    output logic [2:0]      alu_sel,
    output logic            alu_b_imm,
    output logic            alu_a_zero,
    output logic            en_alu,
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic            rf_wsel,
    output logic [15:0]     link,
    output logic            mem_we,
    output logic            mem_oe,
    output logic [3:0]      mem_addr,
    output logic            halted,
    output logic            fault
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    logic [15:0]     ir;
    logic [CNT_W-1:0] tmo_cnt;
    logic            rf_we_q;
    logic            mem_we_q;
    logic [PC_W-1:0] pc_inc;
    opcode_t         opcode;
    dec_t            dec;
    logic            unused_bits;

    assign opcode = opcode_t'(ir[15:12]);
    assign rd_f   = ir[11:8];
    assign rn_f   = ir[7:4];
    assign rm_f   = ir[3:0];
    assign pc_inc = pc + PC_W'(1);
    assign link   = 16'(pc_inc);

    // Write strobes are masked by rst so an aborted WB/MEM cycle never commits.
    assign rf_we  = rf_we_q && !rst;
    assign mem_we = mem_we_q && !rst;

    assign unused_bits = ^rd_data[15:PC_W];

    ctrl_decode u_dec (
        .opcode (ir[15:12]),
        .dec    (dec)
    );

    // Outputs are registered: each transition loads the strobes of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            tmo_cnt    <= '0;
            instr_req  <= 1'b1;
            alu_sel    <= ALU_ADD;
            alu_b_imm  <= 1'b0;
            alu_a_zero <= 1'b0;
            en_alu     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr   <= '0;
            rf_wsel    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            instr_req  <= 1'b0;
            alu_sel    <= ALU_ADD;
            alu_b_imm  <= 1'b0;
            alu_a_zero <= 1'b0;
            en_alu     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr   <= '0;
            rf_wsel    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;

            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        ir    <= instr;
                        state <= DECODE;
                    end else begin
                        instr_req <= 1'b1;
                    end
                end

                DECODE: begin
                    case (dec.cls)
                        CLS_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        CLS_MEM: begin
                            tmo_cnt  <= '0;
                            mem_addr <= rd_f;
                            state    <= MEM;
                            if (opcode == OP_STUR) begin
                                mem_we_q   <= 1'b1;
                                en_alu     <= 1'b1;
                                alu_a_zero <= 1'b1;
                            end else begin
                                mem_oe <= 1'b1;
                            end
                        end
                        CLS_ALU: begin
                            en_alu    <= 1'b1;
                            alu_sel   <= dec.alu_sel;
                            alu_b_imm <= dec.alu_b_imm;
                            state     <= EXEC;
                        end
                        default: state <= EXEC;
                    endcase
                end

                EXEC: begin
                    if (dec.cls == CLS_ALU) begin
                        en_alu    <= 1'b1;
                        alu_sel   <= dec.alu_sel;
                        alu_b_imm <= dec.alu_b_imm;
                        rf_we_q   <= 1'b1;
                        rf_waddr  <= rd_f;
                        state     <= WB;
                    end else begin
                        case (opcode)
                            OP_BL: begin
                                // pc moves only after WB so link still sees the old pc
                                rf_we_q  <= 1'b1;
                                rf_waddr <= 4'hF;
                                rf_wsel  <= 1'b1;
                                state    <= WB;
                            end
                            OP_BEQ: begin
                                pc        <= (rn_data == zext4(rm_f)) ? PC_W'(rd_f) : pc_inc;
                                instr_req <= 1'b1;
                                state     <= FETCH;
                            end
                            default: begin
                                pc        <= rd_data[PC_W-1:0];
                                instr_req <= 1'b1;
                                state     <= FETCH;
                            end
                        endcase
                    end
                end

                MEM: begin
                    if (mem_ack) begin
                        if (opcode == OP_STUR) begin
                            pc        <= pc_inc;
                            instr_req <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            mem_oe   <= 1'b1;
                            rf_we_q  <= 1'b1;
                            rf_waddr <= rn_f;
                            state    <= WB;
                        end
                    end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        tmo_cnt    <= tmo_cnt + CNT_W'(1);
                        mem_we_q   <= mem_we_q;
                        mem_oe     <= mem_oe;
                        mem_addr   <= mem_addr;
                        en_alu     <= en_alu;
                        alu_a_zero <= alu_a_zero;
                    end
                end

                WB: begin
                    pc        <= (opcode == OP_BL) ? PC_W'(rd_f) : pc_inc;
                    instr_req <= 1'b1;
                    state     <= FETCH;
                end

                HALT: state <= HALT;

                default: begin
                    instr_req <= 1'b1;
                    state     <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each instruction pushes its expected
// results to a scoreboard, which is drained against the recorded cycle trace.
module tb_control_unit;

    logic        clk, rst;
    logic [15:0] instr;
    logic        imem_valid, mem_ack;
    logic [15:0] rn_data, rd_data;
    logic [3:0]  pc;
    logic        instr_req;
    logic [3:0]  rd_f, rn_f, rm_f;
    logic [2:0]  alu_sel;
    logic        alu_b_imm, alu_a_zero, en_alu, rf_we, rf_wsel;
    logic [3:0]  rf_waddr, mem_addr;
    logic [15:0] link;
    logic        mem_we, mem_oe, halted, fault;

    control_unit #(.PC_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_valid(imem_valid),
        .mem_ack(mem_ack), .rn_data(rn_data), .rd_data(rd_data),
        .pc(pc), .instr_req(instr_req), .rd_f(rd_f), .rn_f(rn_f), .rm_f(rm_f),
        .alu_sel(alu_sel), .alu_b_imm(alu_b_imm), .alu_a_zero(alu_a_zero),
        .en_alu(en_alu), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
        .link(link), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
        .halted(halted), .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  pc;
        logic        instr_req, en_alu, b_imm, a_zero, rf_we, wsel;
        logic        mem_we, mem_oe, halted, fault;
        logic [2:0]  sel;
        logic [3:0]  waddr, maddr;
        logic [15:0] link;
    } snap_t;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    snap_t tr[$];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_underflow: got 0x%0h expected <none>", got);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.pc = pc; s.instr_req = instr_req; s.en_alu = en_alu; s.b_imm = alu_b_imm;
        s.a_zero = alu_a_zero; s.rf_we = rf_we; s.wsel = rf_wsel; s.mem_we = mem_we;
        s.mem_oe = mem_oe; s.halted = halted; s.fault = fault; s.sel = alu_sel;
        s.waddr = rf_waddr; s.maddr = mem_addr; s.link = link;
        return s;
    endfunction

    function automatic int cnt_we();
        int n = 0;
        foreach (tr[i]) if (tr[i].rf_we === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_oe();
        int n = 0;
        foreach (tr[i]) if (tr[i].mem_oe === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_mwe();
        int n = 0;
        foreach (tr[i]) if (tr[i].mem_we === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_en();
        int n = 0;
        foreach (tr[i]) if (tr[i].en_alu === 1'b1) n++;
        return n;
    endfunction

    // Runs one instruction from its fetch to the next fetch (or halt).
    // mem_ack rises on MEM cycle ack_delay+1; outside MEM it is driven to 'noise'.
    task automatic exec(input logic [15:0] ins, input int ack_delay, input logic noise);
        int  m = 0;
        bit  done = 0;
        tr.delete();
        for (int i = 0; i < 20 && instr_req !== 1'b1; i++) tick();
        mem_ack    = noise;
        instr      = ins;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        instr      = 16'h0000;
        for (int i = 0; i < 40 && !done; i++) begin
            tr.push_back(snap());
            if (instr_req === 1'b1 || halted === 1'b1) begin
                done = 1;
            end else begin
                if ((mem_oe || mem_we) && !rf_we) begin
                    m++;
                    mem_ack = (m == ack_delay + 1);
                end else begin
                    mem_ack = noise;
                end
                tick();
            end
        end
        mem_ack = 1'b0;
        chk("exec_done", 32'(done), 32'd1);
    endtask

    // Strobe exclusivity holds in every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            assert (!(mem_we && mem_oe) && !(en_alu && mem_oe)) else begin
                n_err++;
                $error("FAIL strobe_excl: got we=%0b oe=%0b en=%0b expected no overlap",
                       mem_we, mem_oe, en_alu);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] alu_ins [8] = '{16'h2345, 16'h3111, 16'h4000, 16'h5000,
                                 16'h6000, 16'h7000, 16'h8000, 16'hA000};
    logic [2:0]  alu_exp [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic        imm_exp [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int         bad;
        logic [3:0] exp_pc;

        rst = 1'b1; instr = '0; imem_valid = 1'b0; mem_ack = 1'b0;
        rn_data = '0; rd_data = '0;
        tick(); tick();
        chk("rst.pc", 32'(pc), 0);
        chk("rst.instr_req", 32'(instr_req), 1);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.fault", 32'(fault), 0);
        chk("rst.strobes", {26'd0, rf_we, en_alu, mem_we, mem_oe, alu_b_imm, alu_a_zero}, 0);
        chk("rst.ir", {20'd0, rd_f, rn_f, rm_f}, 0);
        rst = 1'b0;

        // ADDI R2 = R0 + 3
        push("addi.lat", 4); push("addi.pc", 1); push("addi.dec_en", 0);
        push("addi.ex_en", 1); push("addi.ex_sel", 0); push("addi.ex_imm", 1);
        push("addi.ex_we", 0); push("addi.wb_en", 1); push("addi.wb_waddr", 2);
        push("addi.wb_wsel", 0); push("addi.we_cnt", 1);
        exec(16'h1203, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(32'(tr[0].en_alu));
        pop_chk(32'(tr[1].en_alu)); pop_chk(32'(tr[1].sel)); pop_chk(32'(tr[1].b_imm));
        pop_chk(32'(tr[1].rf_we)); pop_chk(32'(tr[2].en_alu)); pop_chk(32'(tr[2].waddr));
        pop_chk(32'(tr[2].wsel)); pop_chk(cnt_we());

        // BEQ taken then not taken
        rn_data = 16'd3;
        push("beq_t.lat", 3); push("beq_t.pc", 5); push("beq_t.we", 0);
        exec(16'hC513, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(cnt_we());
        rn_data = 16'd4;
        push("beq_n.lat", 3); push("beq_n.pc", 6); push("beq_n.we", 0);
        exec(16'hC513, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(cnt_we());

        // BR uses only the low pc bits of Rx[rd]
        rd_data = 16'hFFF3;
        push("br.lat", 3); push("br.pc", 3); push("br.we", 0);
        exec(16'hD000, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(cnt_we());

        // BL at pc=3
        push("bl.lat", 4); push("bl.pc", 9); push("bl.wb_we", 1); push("bl.wb_waddr", 15);
        push("bl.wb_wsel", 1); push("bl.wb_link", 4); push("bl.we_cnt", 1);
        exec(16'hB900, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(32'(tr[2].rf_we));
        pop_chk(32'(tr[2].waddr)); pop_chk(32'(tr[2].wsel)); pop_chk(32'(tr[2].link));
        pop_chk(cnt_we());

        // LDUR with mem_ack on the 4th MEM cycle
        push("ldur.lat", 7); push("ldur.pc", 10); push("ldur.oe_cnt", 5); push("ldur.mwe_cnt", 0);
        push("ldur.maddr", 2); push("ldur.mem4_we", 0); push("ldur.wb_we", 1);
        push("ldur.wb_waddr", 7); push("ldur.wb_wsel", 0); push("ldur.wb_oe", 1);
        push("ldur.en_cnt", 0); push("ldur.we_cnt", 1);
        exec(16'hF270, 3, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(cnt_oe()); pop_chk(cnt_mwe());
        pop_chk(32'(tr[1].maddr)); pop_chk(32'(tr[4].rf_we)); pop_chk(32'(tr[5].rf_we));
        pop_chk(32'(tr[5].waddr)); pop_chk(32'(tr[5].wsel)); pop_chk(32'(tr[5].mem_oe));
        pop_chk(cnt_en()); pop_chk(cnt_we());

        // STUR with immediate ack
        push("stur.lat", 3); push("stur.pc", 11); push("stur.mwe", 1); push("stur.en", 1);
        push("stur.azero", 1); push("stur.sel", 0); push("stur.maddr", 3);
        push("stur.oe_cnt", 0); push("stur.we_cnt", 0);
        exec(16'hE300, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(32'(tr[1].mem_we)); pop_chk(32'(tr[1].en_alu));
        pop_chk(32'(tr[1].a_zero)); pop_chk(32'(tr[1].sel)); pop_chk(32'(tr[1].maddr));
        pop_chk(cnt_oe()); pop_chk(cnt_we());

        // pc=15 then ADD wraps to 0; mem_ack noise must be ignored
        rd_data = 16'h000F;
        push("br15.pc", 15);
        exec(16'hD000, 0, 1'b0);
        pop_chk(32'(pc));
        push("wrap.lat", 4); push("wrap.pc", 0); push("wrap.link", 0); push("wrap.waddr", 1);
        exec(16'h0123, 0, 1'b1);
        pop_chk(tr.size()); pop_chk(32'(pc)); pop_chk(32'(tr[2].link)); pop_chk(32'(tr[2].waddr));

        // Remaining ALU opcode selects
        exp_pc = 4'd0;
        for (int i = 0; i < 8; i++) begin
            exp_pc = exp_pc + 4'd1;
            push($sformatf("alu%0d.sel", i), 32'(alu_exp[i]));
            push($sformatf("alu%0d.imm", i), 32'(imm_exp[i]));
            push($sformatf("alu%0d.lat", i), 4);
            push($sformatf("alu%0d.pc", i), 32'(exp_pc));
            exec(alu_ins[i], 0, 1'b0);
            pop_chk(32'(tr[1].sel)); pop_chk(32'(tr[1].b_imm));
            pop_chk(tr.size()); pop_chk(32'(pc));
        end

        // STUR timeout at pc=8
        push("sto.lat", 17); push("sto.mwe_cnt", 15); push("sto.fault", 1); push("sto.halted", 1);
        push("sto.end_mwe", 0); push("sto.end_en", 0); push("sto.pc", 8);
        exec(16'hE500, 99, 1'b0);
        pop_chk(tr.size()); pop_chk(cnt_mwe()); pop_chk(32'(fault)); pop_chk(32'(halted));
        pop_chk(32'(mem_we)); pop_chk(32'(en_alu)); pop_chk(32'(pc));
        bad = 0;
        imem_valid = 1'b1; instr = 16'h1203; mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_req !== 1'b0 || halted !== 1'b1 || fault !== 1'b1 || mem_we !== 1'b0 ||
                mem_oe !== 1'b0 || en_alu !== 1'b0 || rf_we !== 1'b0 || pc !== 4'd8) bad++;
        end
        imem_valid = 1'b0; mem_ack = 1'b0;
        chk("sto.hold_bad", bad, 0);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("sto_rst.pc", 32'(pc), 0);
        chk("sto_rst.fault", 32'(fault), 0);
        chk("sto_rst.halted", 32'(halted), 0);
        chk("sto_rst.instr_req", 32'(instr_req), 1);

        // HALT opcode is absorbing
        push("halt.lat", 2); push("halt.halted", 1); push("halt.fault", 0);
        exec(16'h9000, 0, 1'b0);
        pop_chk(tr.size()); pop_chk(32'(halted)); pop_chk(32'(fault));
        bad = 0;
        imem_valid = 1'b1; instr = 16'h0123;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_req !== 1'b0 || halted !== 1'b1 || rf_we !== 1'b0 || en_alu !== 1'b0 ||
                pc !== 4'd0) bad++;
        end
        imem_valid = 1'b0;
        chk("halt.hold_bad", bad, 0);

        // Reset during WB suppresses the write
        rst = 1'b1; tick(); rst = 1'b0;
        instr = 16'h0A12; imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        tick(); tick();
        chk("mwb.we_pre", 32'(rf_we), 1);
        rst = 1'b1;
        #1;
        chk("mwb.we_gated", 32'(rf_we), 0);
        tick();
        rst = 1'b0;
        chk("mwb.pc", 32'(pc), 0);
        chk("mwb.instr_req", 32'(instr_req), 1);
        chk("mwb.en_alu", 32'(en_alu), 0);

        chk("sb.left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
